// File: rtl/comb_pkg.sv
// comb_pkg -- shared FSM states, Q15 unity and saturation helper for comb_filter_lbcf. Rev 1.0
`default_nettype none

package comb_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_IDLE  = 3'd1,
      ST_READ  = 3'd2,
      ST_CALC  = 3'd3,
      ST_WRITE = 3'd4
   } comb_state_t;

   localparam int Q15_ONE = 32768;

   function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/comb_delay_ram.sv
// comb_delay_ram -- single-port delay line RAM, synchronous read, array not reset. Rev 1.0
`default_nettype none

module comb_delay_ram #(
   parameter int DW    = 16,
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

`default_nettype wire

// File: rtl/comb_filter_lbcf.sv
// comb_filter_lbcf -- feedback comb filter with one-pole low-pass damping in the loop. Rev 1.0
`default_nettype none

module comb_filter_lbcf
   import comb_pkg::*;
#(
   parameter int DW        = 16,
   parameter int MAX_DELAY = 4096,
   parameter int CW        = 16,
   localparam int ADDR     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [DW-1:0]   in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ADDR-1:0] delay_len,
   input  logic [CW-1:0]   feedback,
   input  logic [CW-1:0]   damp,
   input  logic            clear_req,
   output logic [DW-1:0]   out_data,
   output logic            out_valid
);

   localparam int LW = ADDR + 1;
   localparam int PW = DW + CW + 3;
   localparam logic [ADDR-1:0] LAST = ADDR'(MAX_DELAY - 1);

   comb_state_t state_q, state_d;

   logic [ADDR-1:0]      clr_addr, ptr;
   logic [LW-1:0]        len_q, req_len, eff_len;
   logic signed [DW-1:0] x_q, lp_state, lp_q, w_q;
   logic [CW-1:0]        g_q, d_q;

   logic                 ram_we;
   logic [ADDR-1:0]      ram_addr;
   logic [DW-1:0]        ram_wdata, rd_data;

   logic signed [CW+1:0] d_s, g_s, one_m_d;
   logic signed [PW-1:0] mix, fb, sum;
   logic signed [DW-1:0] y, lp_w, w_val;

   comb_delay_ram #(.DW(DW), .DEPTH(MAX_DELAY), .AW(ADDR)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (rd_data)
   );

   assign in_ready = (state_q == ST_IDLE);
   assign req_len  = LW'(delay_len);

   always_comb begin
      eff_len = req_len;
      if (req_len == '0) eff_len = LW'(1);
      else if (req_len > LW'(MAX_DELAY)) eff_len = LW'(MAX_DELAY);
   end

   // RAM port is shared: the clear sweep owns it in CLEAR, the sample pointer otherwise.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = ptr;
      ram_wdata = w_q;
      if (state_q == ST_CLEAR) begin
         ram_we    = 1'b1;
         ram_addr  = clr_addr;
         ram_wdata = '0;
      end else if (state_q == ST_WRITE) begin
         ram_we    = 1'b1;
      end
   end

   always_comb begin
      y       = rd_data;
      d_s     = {2'b00, d_q};
      g_s     = {2'b00, g_q};
      one_m_d = (CW+2)'(Q15_ONE) - d_s;
      mix     = PW'(y) * PW'(one_m_d) + PW'(lp_state) * PW'(d_s);
      lp_w    = DW'(mix >>> 15);
      fb      = (PW'(lp_w) * PW'(g_s)) >>> 15;
      sum     = PW'(x_q) + fb;
      w_val   = DW'(sat_w(64'(sum), DW));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_CLEAR;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR: if (!clear_req && clr_addr == LAST) state_d = ST_IDLE;
         ST_IDLE: begin
            if (clear_req)     state_d = ST_CLEAR;
            else if (in_valid) state_d = ST_READ;
         end
         ST_READ:  state_d = clear_req ? ST_CLEAR : ST_CALC;
         ST_CALC:  state_d = clear_req ? ST_CLEAR : ST_WRITE;
         ST_WRITE: state_d = clear_req ? ST_CLEAR : ST_IDLE;
         default:  state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clr_addr  <= '0;
         ptr       <= '0;
         lp_state  <= '0;
         lp_q      <= '0;
         w_q       <= '0;
         x_q       <= '0;
         g_q       <= '0;
         d_q       <= '0;
         len_q     <= LW'(1);
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state_q)
            ST_CLEAR: begin
               lp_state <= '0;
               if (clear_req || clr_addr == LAST) clr_addr <= '0;
               else                               clr_addr <= clr_addr + ADDR'(1);
            end
            ST_IDLE: begin
               if (in_valid && !clear_req) begin
                  x_q   <= in_data;
                  g_q   <= feedback;
                  d_q   <= damp;
                  len_q <= eff_len;
                  if (LW'(ptr) >= eff_len) ptr <= '0;
               end
            end
            ST_CALC: begin
               if (!clear_req) begin
                  lp_q      <= lp_w;
                  w_q       <= w_val;
                  out_data  <= rd_data;
                  out_valid <= 1'b1;
               end
            end
            ST_WRITE: begin
               lp_state <= lp_q;
               ptr      <= (LW'(ptr) == len_q - LW'(1)) ? '0 : ptr + ADDR'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/comb_filter_lbcf.md
COMB_FILTER_LBCF -- requirements
Module: comb_filter_lbcf

Interface
REQ-001 SHALL have parameter DW, default 16: sample width, signed two's complement.
REQ-002 SHALL have parameter MAX_DELAY, default 4096: delay-line depth in samples; address width is clog2(MAX_DELAY).
REQ-003 SHALL have parameter CW, default 16: coefficient width; coefficients are unsigned Q0.15.
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  DW: input sample.
REQ-007 SHALL have port in_valid  input  1: in_data is valid.
REQ-008 SHALL have port in_ready  output  1: block accepts a sample this cycle.
REQ-009 SHALL have port delay_len  input  ADDR: active delay length; 0 is treated as 1; values above MAX_DELAY are clamped to MAX_DELAY.
REQ-010 SHALL have port feedback  input  CW: feedback gain g.
REQ-011 SHALL have port damp  input  CW: low-pass damping d.
REQ-012 SHALL have port clear_req  input  1: one-cycle pulse that restarts buffer clearing.
REQ-013 SHALL have port out_data  output  DW: delayed sample.
REQ-014 SHALL have port out_valid  output  1: one-cycle strobe qualifying out_data; no backpressure.

Function
REQ-015 SHALL implement the FSM CLEAR -> IDLE -> READ -> CALC -> WRITE -> IDLE.
REQ-016 CLEAR SHALL write zero to addresses 0..MAX_DELAY-1, one per cycle, reset lp_state to 0, then enter IDLE; it takes MAX_DELAY cycles.
REQ-017 in_ready SHALL be 1 only in IDLE; a sample is accepted when in_valid and in_ready are both 1.
REQ-018 On accept, the block SHALL latch in_data, feedback, damp and the effective delay_len; if ptr >= the new length, ptr SHALL become 0.
REQ-019 READ SHALL issue a synchronous read at ptr; y is the read data.
REQ-020 CALC SHALL compute lp = (y*(32768-d) + lp_state*d) >>> 15, full-precision product, arithmetic shift.
REQ-021 CALC SHALL compute w = sat_DW(x + ((lp*g) >>> 15)), saturating to [-2^(DW-1), 2^(DW-1)-1].
REQ-022 WRITE SHALL write w at ptr and set lp_state to lp.
REQ-023 In WRITE, ptr SHALL become ptr+1, wrapping to 0 at len-1.
REQ-024 In WRITE, out_data SHALL be y and out_valid SHALL be 1 for exactly that cycle.
REQ-025 Latency SHALL be: accept at cycle T gives out_valid at T+3; maximum throughput is 1 sample per 4 cycles.
REQ-026 With d = 0 the block SHALL behave as a plain feedback comb.
REQ-027 A clear_req seen in IDLE, READ or CALC SHALL abort the sample (no write, no out_valid) and enter CLEAR.
REQ-028 A clear_req seen in CLEAR SHALL restart the clear at address 0.
REQ-029 A clear_req seen in WRITE SHALL complete that cycle, then enter CLEAR.
REQ-030 Between accepts, changes on delay_len, feedback and damp SHALL have no effect.

Reset
REQ-031 Asserting reset SHALL asynchronously set state=CLEAR, clear address=0, ptr=0, lp_state=0, out_data=0, out_valid=0, in_ready=0.
REQ-032 Release of reset SHALL start a full clear; RAM contents are not assumed zero at power-up.
REQ-033 Reset mid-sample SHALL drop the sample with no out_valid.

Structure
REQ-034 Package comb_pkg SHALL hold the FSM state enum, Q15_ONE=32768 and the saturation function.
REQ-035 Sub-module comb_delay_ram SHALL be a single-port, synchronous-read, MAX_DELAY x DW RAM with no reset on its array.
REQ-036 Arithmetic, FSM and pointers SHALL stay in comb_filter_lbcf.

Verification
REQ-037 Reset release: in_ready=0 for exactly 4096 cycles, then 1; out_valid=0 throughout.
REQ-038 Impulse, len=4, g=16384, d=0, input 16384 then zeros: outputs 0,0,0,0,16384,0,0,0,8192,0,0,0,4096.
REQ-039 Saturation, len=1, g=32767, d=0, input 32767 repeated: outputs 0,32767,32767; no wrap; -32768 input mirrors to -32768.
REQ-040 Damping, len=1, g=32767, d=16384, input 16384 then zeros: outputs 0,16384, then decaying per REQ-020/021, matched against a bit-exact model.
REQ-041 Length change, len 8 -> 3 with ptr=5 at accept: ptr becomes 0; following outputs repeat with period 3.
REQ-042 clear_req in CALC: no out_valid for that sample, in_ready low for 4096 cycles, next outputs all 0 until refilled.
